// File: rtl/lsu_bus_master_pkg.sv
// Shared definitions for the LSU bus master: access-width codes, FSM states,
// byte-enable patterns and the alignment check.
package lsu_bus_master_pkg;

   typedef enum logic [1:0] {
      OP_WORD = 2'b00,
      OP_HALF = 2'b01,
      OP_BYTE = 2'b10,
      OP_ILL  = 2'b11
   } op_width_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_DONE
   } state_e;

   localparam logic [3:0] BE_WORD    = 4'b1111;
   localparam logic [3:0] BE_HALF_LO = 4'b0011;
   localparam logic [3:0] BE_HALF_HI = 4'b1100;
   localparam logic [3:0] BE_BYTE0   = 4'b0001;

   function automatic logic addr_ok(input op_width_e op, input logic [1:0] lo);
      case (op)
         OP_WORD: return (lo == 2'b00);
         OP_HALF: return !lo[0];
         OP_BYTE: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: byte enables, store-data replication and
// load-data extraction with sign/zero extension.
module lsu_lane_align
   import lsu_bus_master_pkg::*;
(
   input  op_width_e   op_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] wd_i,
   input  logic        load_signed_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o
);

   logic [15:0] half;
   logic [7:0]  byt;

   always_comb begin
      be_o    = '0;
      wdata_o = wd_i;
      case (op_i)
         OP_WORD: be_o = BE_WORD;
         OP_HALF: begin
            be_o    = addr_lo_i[1] ? BE_HALF_HI : BE_HALF_LO;
            wdata_o = {2{wd_i[15:0]}};
         end
         OP_BYTE: begin
            be_o    = BE_BYTE0 << addr_lo_i;
            wdata_o = {4{wd_i[7:0]}};
         end
         default: be_o = '0;
      endcase
   end

   always_comb begin
      half = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      case (addr_lo_i)
         2'd0:    byt = rdata_i[7:0];
         2'd1:    byt = rdata_i[15:8];
         2'd2:    byt = rdata_i[23:16];
         default: byt = rdata_i[31:24];
      endcase
      case (op_i)
         OP_HALF: rdata_o = {{16{load_signed_i & half[15]}}, half};
         OP_BYTE: rdata_o = {{24{load_signed_i & byt[7]}}, byt};
         default: rdata_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/lsu_bus_master.sv
// CPU-side load/store initiator on a req/ack word bus, with alignment
// checking, lane handling and an acknowledge timeout.
module lsu_bus_master
   import lsu_bus_master_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 5
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Req,
   input  logic        MemWrite,
   input  logic [1:0]  OpWidth,
   input  logic        LoadSigned,
   input  logic [31:0] Addr,
   input  logic [31:0] WD,
   input  logic [31:0] WPC,
   output logic        Busy,
   output logic        Done,
   output logic [31:0] RD,
   output logic        AddrErr,
   output logic        BusErr,
   output logic        BusReq,
   output logic        BusWe,
   output logic [31:0] BusAddr,
   output logic [3:0]  BusBE,
   output logic [31:0] BusWData,
   input  logic        BusAck,
   input  logic [31:0] BusRData
);

   state_e           state_q;
   op_width_e        op_q;
   logic [1:0]       addr_lo_q;
   logic             signed_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   op_width_e        op_in, op_sel;
   logic [1:0]       lo_sel;
   logic             sgn_sel;
   logic [3:0]       be;
   logic [31:0]      wdata, rd_ext;

   // WPC only feeds the store trace, which has no hardware counterpart.
   logic             wpc_unused;
   assign wpc_unused = ^WPC;

   assign op_in = op_width_e'(OpWidth);
   assign cnt_d = cnt_q + 1'b1;

   // One lane unit serves both directions: live inputs while idle, captured ones afterwards.
   assign op_sel  = (state_q == ST_IDLE) ? op_in      : op_q;
   assign lo_sel  = (state_q == ST_IDLE) ? Addr[1:0]  : addr_lo_q;
   assign sgn_sel = (state_q == ST_IDLE) ? LoadSigned : signed_q;

   lsu_lane_align u_align (
      .op_i          (op_sel),
      .addr_lo_i     (lo_sel),
      .wd_i          (WD),
      .load_signed_i (sgn_sel),
      .rdata_i       (BusRData),
      .be_o          (be),
      .wdata_o       (wdata),
      .rdata_o       (rd_ext)
   );

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state_q   <= ST_IDLE;
         op_q      <= OP_WORD;
         addr_lo_q <= '0;
         signed_q  <= 1'b0;
         cnt_q     <= '0;
         Busy      <= 1'b0;
         Done      <= 1'b0;
         RD        <= '0;
         AddrErr   <= 1'b0;
         BusErr    <= 1'b0;
         BusReq    <= 1'b0;
         BusWe     <= 1'b0;
         BusAddr   <= '0;
         BusBE     <= '0;
         BusWData  <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               Done    <= 1'b0;
               AddrErr <= 1'b0;
               BusErr  <= 1'b0;
               if (Req) begin
                  op_q      <= op_in;
                  addr_lo_q <= Addr[1:0];
                  signed_q  <= LoadSigned;
                  cnt_q     <= '0;
                  Busy      <= 1'b1;
                  if (addr_ok(op_in, Addr[1:0])) begin
                     state_q  <= ST_ISSUE;
                     BusReq   <= 1'b1;
                     BusWe    <= MemWrite;
                     BusAddr  <= {Addr[31:2], 2'b00};
                     BusBE    <= be;
                     BusWData <= wdata;
                  end else begin
                     state_q <= ST_DONE;
                     Done    <= 1'b1;
                     AddrErr <= 1'b1;
                  end
               end
            end
            ST_ISSUE: begin
               if (BusAck) begin
                  state_q <= ST_DONE;
                  BusReq  <= 1'b0;
                  Done    <= 1'b1;
                  if (!BusWe) RD <= rd_ext;
               end else if (cnt_d == CNT_W'(TIMEOUT)) begin
                  state_q <= ST_DONE;
                  BusReq  <= 1'b0;
                  Done    <= 1'b1;
                  BusErr  <= 1'b1;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               Done    <= 1'b0;
               Busy    <= 1'b0;
               AddrErr <= 1'b0;
               BusErr  <= 1'b0;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_bus_master.sv
// Directed bench for lsu_bus_master with hand-computed expected values.
module tb_lsu_bus_master;

   logic        Clk = 1'b0, Reset = 1'b0, Req = 1'b0, MemWrite = 1'b0;
   logic        LoadSigned = 1'b0, BusAck = 1'b0;
   logic [1:0]  OpWidth = '0;
   logic [31:0] Addr = '0, WD = '0, WPC = '0, BusRData = '0;
   logic        Busy, Done, AddrErr, BusErr, BusReq, BusWe;
   logic [31:0] RD, BusAddr, BusWData;
   logic [3:0]  BusBE;

   int   n_cmp = 0, n_bad = 0, n_req = 0, exp_req = 0;
   logic req_d = 1'b0;

   lsu_bus_master #(.TIMEOUT(16), .CNT_W(5)) dut (
      .Clk(Clk), .Reset(Reset), .Req(Req), .MemWrite(MemWrite), .OpWidth(OpWidth),
      .LoadSigned(LoadSigned), .Addr(Addr), .WD(WD), .WPC(WPC), .Busy(Busy),
      .Done(Done), .RD(RD), .AddrErr(AddrErr), .BusErr(BusErr), .BusReq(BusReq),
      .BusWe(BusWe), .BusAddr(BusAddr), .BusBE(BusBE), .BusWData(BusWData),
      .BusAck(BusAck), .BusRData(BusRData)
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk) begin
      req_d <= BusReq;
      if (BusReq && !req_d) n_req <= n_req + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Flags packed as {Busy, Done, AddrErr, BusErr, BusReq}.
   task automatic status(input string tag, input logic [4:0] exp);
      chk(tag, {27'd0, Busy, Done, AddrErr, BusErr, BusReq}, {27'd0, exp});
   endtask

   task automatic xfer(input string tag, input logic we, input logic [1:0] op,
                       input logic sgn, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rdata, input int waits, input logic hold,
                       input logic [3:0] exp_be, input logic [31:0] exp_wd);
      MemWrite = we; OpWidth = op; LoadSigned = sgn; Addr = addr; WD = wd;
      WPC = 32'h100 + addr; Req = 1'b1;
      @(negedge Clk);
      if (!hold) Req = 1'b0;
      exp_req++;
      status({tag, ".issue"}, 5'b10001);
      chk({tag, ".be"}, {28'd0, BusBE}, {28'd0, exp_be});
      chk({tag, ".addr"}, BusAddr, {addr[31:2], 2'b00});
      chk({tag, ".wdata"}, BusWData, exp_wd);
      chk({tag, ".we"}, {31'd0, BusWe}, {31'd0, we});
      for (int i = 0; i < waits; i++) begin
         @(negedge Clk);
         status({tag, ".wait"}, 5'b10001);
      end
      BusAck = 1'b1; BusRData = rdata;
      @(negedge Clk);
      BusAck = 1'b0; BusRData = 32'h5A5A5A5A;
      if (we) $display("@%h: *%h <= %h", WPC, addr, wd);
      status({tag, ".done"}, 5'b11000);
      @(negedge Clk);
      status({tag, ".idle"}, 5'b00000);
      Req = 1'b0;
   endtask

   task automatic aerr(input string tag, input logic [1:0] op, input logic [31:0] addr,
                       input logic [31:0] exp_rd);
      MemWrite = 1'b0; OpWidth = op; Addr = addr; Req = 1'b1;
      @(negedge Clk);
      Req = 1'b0;
      status({tag, ".done"}, 5'b11100);
      @(negedge Clk);
      status({tag, ".idle"}, 5'b00000);
      chk({tag, ".rd"}, RD, exp_rd);
   endtask

   initial begin
      repeat (2) @(negedge Clk);
      status("reset.flags", 5'b00000);
      chk("reset.rd", RD, 32'h0);
      chk("reset.addr", BusAddr, 32'h0);
      chk("reset.wdata", BusWData, 32'h0);
      chk("reset.be_we", {27'd0, BusBE, BusWe}, 32'h0);
      Reset = 1'b1;
      @(negedge Clk);

      xfer("sw",   1'b1, 2'b00, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1, 1'b0, 4'b1111, 32'hDEADBEEF);
      xfer("lb_s", 1'b0, 2'b10, 1'b1, 32'h13, 32'h0, 32'h80AABBCC, 0, 1'b0, 4'b1000, 32'h0);
      chk("lb_s.rd", RD, 32'hFFFFFF80);
      xfer("lb_u", 1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 32'h80AABBCC, 2, 1'b0, 4'b1000, 32'h0);
      chk("lb_u.rd", RD, 32'h00000080);
      xfer("sh",   1'b1, 2'b01, 1'b0, 32'h22, 32'h1234ABCD, 32'h0, 0, 1'b0, 4'b1100, 32'hABCDABCD);
      chk("sh.rd_kept", RD, 32'h00000080);
      xfer("lh_s", 1'b0, 2'b01, 1'b1, 32'h20, 32'h000000EE, 32'h1234F00D, 0, 1'b0, 4'b0011, 32'h00EE00EE);
      chk("lh_s.rd", RD, 32'hFFFFF00D);
      xfer("lbu1", 1'b0, 2'b10, 1'b0, 32'h11, 32'h000000A5, 32'h0000C300, 0, 1'b0, 4'b0010, 32'hA5A5A5A5);
      chk("lbu1.rd", RD, 32'h000000C3);
      // Ack arrives on the very edge the timeout would expire; held Req must not re-issue.
      xfer("lw_hold", 1'b0, 2'b00, 1'b1, 32'h40, 32'h11112222, 32'h87654321, 15, 1'b1, 4'b1111, 32'h11112222);
      chk("lw_hold.rd", RD, 32'h87654321);
      @(negedge Clk);
      status("lw_hold.no_reissue", 5'b00000);

      aerr("lh_mis", 2'b01, 32'h21, 32'h87654321);
      aerr("lw_mis", 2'b00, 32'h42, 32'h87654321);
      aerr("op_ill", 2'b11, 32'h40, 32'h87654321);

      MemWrite = 1'b0; OpWidth = 2'b00; Addr = 32'h50; Req = 1'b1;
      @(negedge Clk);
      Req = 1'b0;
      exp_req++;
      status("tmo.issue", 5'b10001);
      repeat (15) begin
         @(negedge Clk);
         status("tmo.wait", 5'b10001);
      end
      @(negedge Clk);
      status("tmo.done", 5'b11010);
      chk("tmo.rd", RD, 32'h87654321);
      @(negedge Clk);
      status("tmo.idle", 5'b00000);

      MemWrite = 1'b1; OpWidth = 2'b00; Addr = 32'h60; WD = 32'h0BADF00D; Req = 1'b1;
      @(negedge Clk);
      Req = 1'b0;
      exp_req++;
      status("rst.issue", 5'b10001);
      Reset = 1'b0;
      @(negedge Clk);
      Reset = 1'b1;
      status("rst.abort", 5'b00000);
      BusAck = 1'b1;
      @(negedge Clk);
      BusAck = 1'b0;
      status("rst.stray_ack", 5'b00000);
      chk("rst.rd", RD, 32'h0);
      @(negedge Clk);
      status("rst.quiet", 5'b00000);

      chk("busreq.count", n_req, exp_req);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
